// File: rtl/alu_pkg.sv
// Shared ALU op encodings, RISC-V opcode constants and the per-entry flag
// record used by the issue stage queue.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int QDEPTH = 2;

    // Result and tag widths are module parameters, so they live beside this
    // record in the queue rather than inside it.
    typedef struct packed {
        logic       zero;
        logic [2:0] op;
        logic       taken;
        logic       illegal;
    } entry_flags_t;

endpackage

// File: rtl/alu_ctrl.sv
// Decodes opcode/funct3/funct7b5 into ALU op, operand-B select, branch and
// illegal indications. Illegal encodings leave op at AND.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] op,
    output logic       bsel,
    output logic       is_branch,
    output logic       illegal
);
    always_comb begin
        op        = ALU_AND;
        bsel      = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000:  op = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                bsel = 1'b1;
                case (funct3)
                    3'b000:  op = ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                op   = ALU_ADD;
                bsel = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    op        = ALU_SUB;
                    is_branch = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/yAlu.sv
// Existing 32-bit combinational ALU: op[2] inverts B with carry-in,
// op[1:0] selects AND / OR / ADD-SUB / SLT.
module yAlu (
    output logic [31:0] z,
    output logic        ex,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op
);
    logic [31:0] bb;
    logic [31:0] sum;
    logic        slt;

    assign bb  = op[2] ? ~b : b;
    assign sum = a + bb + {31'b0, op[2]};
    // Sign of a-b is only trustworthy when the operand signs agree.
    assign slt = (a[31] != b[31]) ? a[31] : sum[31];

    always_comb begin
        case (op[1:0])
            2'b00:   z = a & b;
            2'b01:   z = a | b;
            2'b10:   z = sum;
            default: z = {31'b0, slt};
        endcase
    end

    assign ex = (z == 32'b0);

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decode, operand-B select, yAlu evaluation and a
// 2-entry in-order skid queue toward the memory stage.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [2:0]       out_op,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [TAGW-1:0]  out_tag
);
    logic [2:0]       dec_op;
    logic             bsel;
    logic             is_branch;
    logic             illegal;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_z;
    logic             alu_zero_unused;
    logic [WIDTH-1:0] new_result;
    entry_flags_t     new_flags;

    alu_ctrl u_ctrl (
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7b5  (in_funct7b5),
        .op        (dec_op),
        .bsel      (bsel),
        .is_branch (is_branch),
        .illegal   (illegal)
    );

    assign opb = bsel ? in_imm : in_rs2;

    // The ALU's own zero flag is ignored; zero is derived from the
    // possibly-forced result that actually gets queued.
    yAlu u_alu (
        .z  (alu_z),
        .ex (alu_zero_unused),
        .a  (in_rs1),
        .b  (opb),
        .op (dec_op)
    );

    always_comb begin
        new_result        = illegal ? '0 : alu_z;
        new_flags.zero    = (new_result == '0);
        new_flags.op      = dec_op;
        new_flags.illegal = illegal;
        // funct3[0] distinguishes BNE from BEQ
        new_flags.taken   = is_branch & (in_funct3[0] ? ~new_flags.zero : new_flags.zero);
    end

    logic [QDEPTH-1:0][WIDTH-1:0] q_result;
    logic [QDEPTH-1:0][TAGW-1:0]  q_tag;
    entry_flags_t [QDEPTH-1:0]    q_flags;
    logic                         head;
    logic [1:0]                   count;
    logic                         tail;
    logic                         push;
    logic                         pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign tail      = head ^ count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_result <= '0;
            q_tag    <= '0;
            q_flags  <= '0;
            head     <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                q_result[tail] <= new_result;
                q_tag[tail]    <= in_tag;
                q_flags[tail]  <= new_flags;
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_result  = q_result[head];
    assign out_tag     = q_tag[head];
    assign out_zero    = q_flags[head].zero;
    assign out_op      = q_flags[head].op;
    assign out_taken   = q_flags[head].taken;
    assign out_illegal = q_flags[head].illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode/ALU results, branch decisions,
// backpressure ordering, illegal entries and mid-queue reset.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [2:0]  out_op;
    logic        out_taken;
    logic        out_illegal;
    logic [4:0]  out_tag;

    int passed = 0;
    int total  = 0;

    alu_issue_stage #(.WIDTH(32), .TAGW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_op(out_op),
        .out_taken(out_taken), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] tag);
        in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
        in_rs1 = a; in_rs2 = b; in_imm = imm; in_tag = tag;
        in_valid = 1'b1;
    endtask

    // One-cycle offer, then idle inputs.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [4:0] tag);
        drive(opc, f3, f7, a, b, imm, tag);
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] res, input logic z,
                            input logic [2:0] op, input logic tk, input logic ill,
                            input logic [4:0] t);
        chk({tag, ".valid"},   {31'b0, out_valid},   32'd1);
        chk({tag, ".result"},  out_result,           res);
        chk({tag, ".zero"},    {31'b0, out_zero},    {31'b0, z});
        chk({tag, ".op"},      {29'b0, out_op},      {29'b0, op});
        chk({tag, ".taken"},   {31'b0, out_taken},   {31'b0, tk});
        chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
        chk({tag, ".tag"},     {27'b0, out_tag},     {27'b0, t});
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_tag = '0;
        step(); step();

        chk("rst.valid",   {31'b0, out_valid},   32'd0);
        chk("rst.ready",   {31'b0, in_ready},    32'd1);
        chk("rst.result",  out_result,           32'd0);
        chk("rst.zero",    {31'b0, out_zero},    32'd0);
        chk("rst.op",      {29'b0, out_op},      32'd0);
        chk("rst.taken",   {31'b0, out_taken},   32'd0);
        chk("rst.illegal", {31'b0, out_illegal}, 32'd0);
        chk("rst.tag",     {27'b0, out_tag},     32'd0);
        rst = 1'b0;
        step();

        // Streaming with out_ready high: each send pops the previous head.
        send(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 5'd1);
        chk_head("add", 32'd12, 1'b0, 3'b010, 1'b0, 1'b0, 5'd1);
        send(7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'd8, 5'd2);
        chk_head("beq", 32'd0, 1'b1, 3'b110, 1'b1, 1'b0, 5'd2);
        send(7'b1100011, 3'b001, 1'b0, 32'h1234, 32'h1234, 32'd8, 5'd3);
        chk_head("bne", 32'd0, 1'b1, 3'b110, 1'b0, 1'b0, 5'd3);
        send(7'b1100011, 3'b001, 1'b0, 32'd9, 32'd4, 32'd0, 5'd4);
        chk_head("bne_tk", 32'd5, 1'b0, 3'b110, 1'b1, 1'b0, 5'd4);
        send(7'b0010011, 3'b010, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd5);
        chk_head("slt_neg", 32'd1, 1'b0, 3'b111, 1'b0, 1'b0, 5'd5);
        send(7'b0010011, 3'b010, 1'b0, 32'd3, 32'd100, 32'hFFFF_FFFC, 5'd6);
        chk_head("slt_pos", 32'd0, 1'b1, 3'b111, 1'b0, 1'b0, 5'd6);
        send(7'b0110011, 3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd7);
        chk_head("and", 32'h0000_F000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd7);
        send(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 5'd8);
        chk_head("sub", 32'd7, 1'b0, 3'b110, 1'b0, 1'b0, 5'd8);
        send(7'b0000011, 3'b101, 1'b0, 32'h100, 32'hDEAD, 32'h20, 5'd9);
        chk_head("load", 32'h120, 1'b0, 3'b010, 1'b0, 1'b0, 5'd9);
        step();
        chk("drain.valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: fill both slots, third offer must wait.
        out_ready = 1'b0;
        send(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1);
        chk("bp.ready1", {31'b0, in_ready}, 32'd1);
        send(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0, 5'd2);
        chk("bp.ready2", {31'b0, in_ready}, 32'd0);
        drive(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0, 5'd3);
        step();
        chk("bp.ready3", {31'b0, in_ready}, 32'd0);
        chk_head("bp.hold1", 32'd2, 1'b0, 3'b010, 1'b0, 1'b0, 5'd1);
        step();
        chk_head("bp.hold2", 32'd2, 1'b0, 3'b010, 1'b0, 1'b0, 5'd1);
        out_ready = 1'b1;
        step();
        chk_head("bp.t2", 32'd4, 1'b0, 3'b010, 1'b0, 1'b0, 5'd2);
        chk("bp.ready4", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk_head("bp.t3", 32'd6, 1'b0, 3'b010, 1'b0, 1'b0, 5'd3);
        step();
        chk("bp.empty", {31'b0, out_valid}, 32'd0);

        // Illegal entry queued between two legal ones.
        out_ready = 1'b0;
        send(7'b0110011, 3'b000, 1'b0, 32'd10, 32'd20, 32'd0, 5'd4);
        send(7'b1110011, 3'b000, 1'b0, 32'hFFFF, 32'hFFFF, 32'd0, 5'd5);
        chk_head("il.t4", 32'd30, 1'b0, 3'b010, 1'b0, 1'b0, 5'd4);
        drive(7'b0010011, 3'b110, 1'b0, 32'h0F, 32'd0, 32'hF0, 5'd6);
        out_ready = 1'b1;
        step();
        chk_head("il.t5", 32'd0, 1'b1, 3'b000, 1'b0, 1'b1, 5'd5);
        step();
        in_valid = 1'b0;
        chk_head("il.t6", 32'hFF, 1'b0, 3'b001, 1'b0, 1'b0, 5'd6);
        step();
        chk("il.empty", {31'b0, out_valid}, 32'd0);

        // Reset with two entries held.
        out_ready = 1'b0;
        send(7'b0110011, 3'b000, 1'b0, 32'd4, 32'd4, 32'd0, 5'd7);
        send(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 5'd8);
        chk("mr.full", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr.valid", {31'b0, out_valid}, 32'd0);
        chk("mr.ready", {31'b0, in_ready},  32'd1);
        out_ready = 1'b1;
        step();
        chk("mr.nostale", {31'b0, out_valid}, 32'd0);
        send(7'b0110011, 3'b110, 1'b0, 32'h3, 32'h4, 32'd0, 5'd9);
        chk_head("mr.after", 32'h7, 1'b0, 3'b001, 1'b0, 1'b0, 5'd9);
        step();
        chk("mr.empty", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage front end feeding the existing `yAlu` 32-bit ALU. Accepts decoded instruction fields and register operands from the decode stage under a valid/ready handshake, and generates the 3-bit ALU operation. It selects operand B, evaluates `yAlu`, and buffers the results in a 2-entry in-order skid queue toward the memory stage. Results leave with the zero flag, branch decision and an illegal-operation flag.

## Interface
Parameters:
- `WIDTH`, 32, datapath width (operands, immediate, result)
- `TAGW`, 5, width of the pass-through destination tag

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream offers an instruction
- `in_ready`  out  1  stage can accept; registered, not combinational on `out_ready`
- `in_opcode`  in  7  RISC-V major opcode
- `in_funct3`  in  3  funct3 field
- `in_funct7b5`  in  1  bit 30 of the instruction
- `in_rs1`  in  WIDTH  operand A
- `in_rs2`  in  WIDTH  register operand B
- `in_imm`  in  WIDTH  sign-extended immediate
- `in_tag`  in  TAGW  destination tag, passed through unchanged
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream consumes head entry
- `out_result`  out  WIDTH  ALU result
- `out_zero`  out  1  result equals 0
- `out_op`  out  3  ALU op used
- `out_taken`  out  1  branch taken (branch entries only)
- `out_illegal`  out  1  unsupported instruction
- `out_tag`  out  TAGW  tag of head entry

## Operation
- ALU op codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111 (signed a<b → 1, else 0).
- R-type (0110011): funct3 000 → ADD, or SUB if `funct7b5`=1. funct3 111 → AND. 110 → OR. 010 → SLT. Operand B is `in_rs2`.
- I-ALU (0010011): funct3 000/111/110/010 → ADD/AND/OR/SLT. Operand B is `in_imm`. `funct7b5` is ignored.
- Load (0000011) and store (0100011): ADD with operand B = `in_imm`, for any funct3.
- Branch (1100011): SUB with operand B = `in_rs2`. funct3 000 (BEQ) → taken = zero. funct3 001 (BNE) → taken = !zero.
- Every other opcode/funct3 combination:
  - illegal=1, op=000, result forced to 0, zero=1, taken=0.
  - The entry is still queued in order and is never dropped.
- `out_taken` is 0 for all non-branch entries.
- `out_zero` is computed from the stored result.
- Queue: 2 entries, FIFO order, with a count register 0..2.
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
- `in_ready` = (count < 2), computed from the registered count.
  - When full, no push occurs in that cycle even if a pop happens simultaneously.
- Simultaneous push and pop at count 1: count stays 1, and the new entry becomes head on the next cycle.
- Head outputs are held stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is presented on `out_*` after edge N, if the queue was empty.
- Throughput is 1 per cycle when `out_ready` is held high.
- Reset values:
  - count=0, `out_valid`=0, `in_ready`=1 (the first cycle after reset).
  - `out_result`=0, `out_zero`=0, `out_op`=000, `out_taken`=0, `out_illegal`=0, `out_tag`=0.
- Reset mid-operation discards all queued entries; no pop is reported in the reset cycle.
- Outputs under `out_valid`=0 are don't-care after reset, but must not be X.

## Structure
- Package `alu_pkg`:
  - ALU op localparams (AND/OR/ADD/SUB/SLT).
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH).
  - Entry record fields (result, zero, op, taken, illegal, tag).
- Sub-module `alu_ctrl`: combinational decode of opcode/funct3/funct7b5 into op, bsel, is_branch, illegal.
- Instantiate the existing combinational `yAlu` unmodified, and ignore its own zero output in favour of the registered compare.
- Queue storage: two entry registers plus head pointer and count, all inside `alu_issue_stage`.

## Test plan
- Reset then ADD: R-type, funct3 000, f7b5=0, rs1=5, rs2=7, `out_ready`=1 → next cycle result=12, op=010, zero=0, illegal=0.
- SUB/BEQ taken: branch funct3 000, rs1=rs2=0x1234 → result=0, zero=1, taken=1. Same with BNE → taken=0.
- SLT signed: I-type funct3 010, rs1=0xFFFFFFFF (−1), imm=1 → result=1. Also rs1=3, imm=−4 → result=0.
- Backpressure: `out_ready`=0, push tags 1,2 → `in_ready`=0 after the second push and the third offer is not accepted. Then raise `out_ready` → tags drain 1,2,3 in order, with head held stable while stalled.
- Illegal: opcode 1110011 with rs1=rs2=0xFFFF → illegal=1, result=0, zero=1, queued in order between two legal ops.
- Reset mid-queue: two entries held, `rst`=1 for one cycle → `out_valid`=0, `in_ready`=1, and no stale entry appears afterward.
